// File: rtl/irq_sched.sv
// Interrupt scheduler: edge-pended requests, one-at-a-time handshake with the coprocessor.
// Define IRQ_SCHED_RR_EN for round-robin arbitration (default: lowest line wins).
module irq_sched (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] irq_in,
   input  logic [5:0] irq_mask,
   input  logic       ie,
   input  logic       exl,
   input  logic       cpu_taken,
   input  logic       int_end,
   output logic [5:0] intq,
   output logic [4:0] ExcCode,
   output logic [5:0] dev_ack,
   output logic [5:0] pending,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      SERVE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] pending_q, pending_d;
   logic [5:0] irq_prev_q;
   logic       hist_vld_q;
   logic [2:0] grant_q, grant_d;
   logic [5:0] intq_q, intq_d;
   logic [5:0] dev_ack_q, dev_ack_d;

   logic [5:0] rise;
   logic [5:0] elig;
   logic [5:0] grant_oh;
   logic [2:0] win;
   logic       found;

`ifdef IRQ_SCHED_RR_EN
   logic [2:0] ptr_q, ptr_d;

   always_comb begin
      int j;
      found = 1'b0;
      win   = 3'd0;
      j     = 0;
      for (int k = 1; k <= 6; k++) begin
         j = int'(ptr_q) + k;
         if (j >= 6) j = j - 6;
         if (!found && elig[j]) begin
            found = 1'b1;
            win   = 3'(j);
         end
      end
   end
`else
   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (elig[i]) begin
            found = 1'b1;
            win   = 3'(i);
         end
      end
   end
`endif

   // History is not trusted on the first cycle out of reset, so lines
   // already high then are not mistaken for fresh edges.
   assign rise     = irq_in & ~irq_prev_q & {6{hist_vld_q}};
   assign elig     = pending_q & irq_mask;
   assign grant_oh = 6'b000001 << grant_q;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | rise;
      grant_d   = grant_q;
      intq_d    = intq_q;
      dev_ack_d = 6'd0;
`ifdef IRQ_SCHED_RR_EN
      ptr_d     = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (found && ie && !exl) begin
               state_d = REQ;
               grant_d = win;
               intq_d  = 6'b000001 << win;
            end
         end
         REQ: begin
            if (cpu_taken) begin
               state_d = SERVE;
            end else if (!irq_mask[grant_q] || !ie) begin
               state_d = IDLE;
               intq_d  = 6'd0;
            end
         end
         SERVE: begin
            if (int_end) begin
               state_d   = DONE;
               intq_d    = 6'd0;
               dev_ack_d = grant_oh;
               pending_d = (pending_q & ~grant_oh) | rise;
`ifdef IRQ_SCHED_RR_EN
               ptr_d     = grant_q;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pending_q  <= 6'd0;
         irq_prev_q <= 6'd0;
         hist_vld_q <= 1'b0;
         grant_q    <= 3'd0;
         intq_q     <= 6'd0;
         dev_ack_q  <= 6'd0;
`ifdef IRQ_SCHED_RR_EN
         ptr_q      <= 3'd5;
`endif
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         irq_prev_q <= irq_in;
         hist_vld_q <= 1'b1;
         grant_q    <= grant_d;
         intq_q     <= intq_d;
         dev_ack_q  <= dev_ack_d;
`ifdef IRQ_SCHED_RR_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

   assign intq    = intq_q;
   assign dev_ack = dev_ack_q;
   assign pending = pending_q;
   assign busy    = (state_q != IDLE);
   assign ExcCode = 5'd0;

endmodule

// File: tb/tb_irq_sched.sv
// Directed vector bench for irq_sched (fixed-priority build).
// Table rows drive inputs before an edge and check outputs just after it.
module tb_irq_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] irq_in;
   logic [5:0] irq_mask;
   logic       ie;
   logic       exl;
   logic       cpu_taken;
   logic       int_end;
   logic [5:0] intq;
   logic [4:0] ExcCode;
   logic [5:0] dev_ack;
   logic [5:0] pending;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   irq_sched dut (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in),
      .irq_mask  (irq_mask),
      .ie        (ie),
      .exl       (exl),
      .cpu_taken (cpu_taken),
      .int_end   (int_end),
      .intq      (intq),
      .ExcCode   (ExcCode),
      .dev_ack   (dev_ack),
      .pending   (pending),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [5:0] irq;
      logic [5:0] mask;
      logic       ie;
      logic       exl;
      logic       ct;
      logic       iend;
      logic [5:0] e_intq;
      logic [5:0] e_ack;
      logic [5:0] e_pend;
      logic       e_busy;
   } vec_t;

   vec_t tbl[$];

   function automatic void v(logic r, logic [5:0] irq, logic [5:0] m,
                             logic i_e, logic x, logic ct, logic ie_end,
                             logic [5:0] eq, logic [5:0] ea,
                             logic [5:0] ep, logic eb);
      vec_t t;
      t.rst = r; t.irq = irq; t.mask = m; t.ie = i_e; t.exl = x;
      t.ct = ct; t.iend = ie_end;
      t.e_intq = eq; t.e_ack = ea; t.e_pend = ep; t.e_busy = eb;
      tbl.push_back(t);
   endfunction

   task automatic chk(string name, int row, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
      end
   endtask

   task automatic drive(logic r, logic [5:0] irq, logic [5:0] m,
                        logic i_e, logic x, logic ct, logic ie_end);
      rst = r; irq_in = irq; irq_mask = m; ie = i_e; exl = x;
      cpu_taken = ct; int_end = ie_end;
   endtask

   task automatic check_all(string tag, int row, logic [5:0] eq,
                            logic [5:0] ea, logic [5:0] ep, logic eb);
      chk({tag, "_intq"}, row, {2'b0, intq}, {2'b0, eq});
      chk({tag, "_ack"}, row, {2'b0, dev_ack}, {2'b0, ea});
      chk({tag, "_pend"}, row, {2'b0, pending}, {2'b0, ep});
      chk({tag, "_busy"}, row, {7'b0, busy}, {7'b0, eb});
      chk({tag, "_exc"}, row, {3'b0, ExcCode}, 8'd0);
   endtask

   initial begin
      int n;
      drive(1'b1, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);

      //     rst irq    mask   ie exl ct end  intq   ack    pend   busy
      v(1, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      // single request on line 2
      v(0, 6'h04, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h04, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h04, 6'h00, 6'h04, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h04, 6'h00, 6'h04, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 1, 0, 6'h04, 6'h00, 6'h04, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h04, 6'h00, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      // simultaneous lines 0 and 2
      v(0, 6'h05, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h05, 0);
      v(0, 6'h05, 6'h3F, 1, 0, 0, 0, 6'h01, 6'h00, 6'h05, 1);
      v(0, 6'h05, 6'h3F, 1, 0, 1, 0, 6'h01, 6'h00, 6'h05, 1);
      v(0, 6'h05, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h01, 6'h04, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h04, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h04, 6'h00, 6'h04, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 1, 0, 6'h04, 6'h00, 6'h04, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h04, 6'h00, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      // exl gating
      v(0, 6'h08, 6'h3F, 1, 1, 0, 0, 6'h00, 6'h00, 6'h08, 0);
      v(0, 6'h00, 6'h3F, 1, 1, 0, 0, 6'h00, 6'h00, 6'h08, 0);
      v(0, 6'h00, 6'h3F, 1, 1, 0, 0, 6'h00, 6'h00, 6'h08, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h08, 6'h00, 6'h08, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 1, 0, 6'h08, 6'h00, 6'h08, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h08, 6'h00, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      // mask abort, then abort racing cpu_taken
      v(0, 6'h02, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h02, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h02, 6'h00, 6'h02, 1);
      v(0, 6'h00, 6'h3D, 1, 0, 0, 0, 6'h00, 6'h00, 6'h02, 0);
      v(0, 6'h00, 6'h3D, 1, 0, 0, 0, 6'h00, 6'h00, 6'h02, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h02, 6'h00, 6'h02, 1);
      v(0, 6'h00, 6'h3D, 1, 0, 1, 0, 6'h02, 6'h00, 6'h02, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h02, 6'h00, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      // re-pend racing the DONE clear on line 3
      v(0, 6'h08, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h08, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h08, 6'h00, 6'h08, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 1, 0, 6'h08, 6'h00, 6'h08, 1);
      v(0, 6'h08, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h08, 6'h08, 1);
      v(0, 6'h08, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h08, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h08, 6'h00, 6'h08, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 1, 0, 6'h08, 6'h00, 6'h08, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 1, 6'h00, 6'h08, 6'h00, 1);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      // reset mid-SERVE; lines high across reset must not pend
      v(0, 6'h10, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h10, 0);
      v(0, 6'h10, 6'h3F, 1, 0, 0, 0, 6'h10, 6'h00, 6'h10, 1);
      v(0, 6'h30, 6'h3F, 1, 0, 1, 0, 6'h10, 6'h00, 6'h30, 1);
      v(1, 6'h3F, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      v(0, 6'h3F, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      v(0, 6'h3F, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      v(0, 6'h3F, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h00, 0);
      v(0, 6'h01, 6'h3F, 1, 0, 0, 0, 6'h00, 6'h00, 6'h01, 0);
      v(0, 6'h00, 6'h3F, 1, 0, 0, 0, 6'h01, 6'h00, 6'h01, 1);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].irq, tbl[i].mask, tbl[i].ie,
               tbl[i].exl, tbl[i].ct, tbl[i].iend);
         @(posedge clk);
         #1;
         check_all("vec", i, tbl[i].e_intq, tbl[i].e_ack,
                   tbl[i].e_pend, tbl[i].e_busy);
      end

      // latency, ie abort, and cpu_taken beating an ie abort
      drive(1'b1, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 6'h10, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (n < 6) begin
         @(posedge clk); #1;
         n++;
         if (intq != 6'h00) break;
      end
      chk("lat_edges", 100, 8'(n), 8'd2);
      check_all("lat", 101, 6'h10, 6'h00, 6'h10, 1'b1);
      drive(1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_all("ie_abort", 102, 6'h00, 6'h00, 6'h10, 1'b0);
      drive(1'b0, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_all("rereq", 103, 6'h10, 6'h00, 6'h10, 1'b1);
      drive(1'b0, 6'h00, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_all("ct_wins", 104, 6'h10, 6'h00, 6'h10, 1'b1);
      drive(1'b0, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_all("done", 105, 6'h00, 6'h10, 6'h00, 1'b1);
      drive(1'b0, 6'h00, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_all("idle", 106, 6'h00, 6'h00, 6'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
